// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int ZERO_ADDR = 0;

    // Ceiling log2, with a floor of one bit so DEPTH = 2 still gets a usable address.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset initialisation sequencer: walks every entry writing zero, then
// switches to RUN and raises ready.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr,
    output logic          run,
    output logic          ready
);

    state_t        state;
    logic [AW:0]   cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + (AW+1)'(1);
                    if (cnt == (AW+1)'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    assign clr_en   = (state == CLEAR) && !rst;
    assign clr_addr = cnt[AW-1:0];
    assign run      = (state == RUN);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write priority, same-cycle
// bypass, optional hardwired zero entry and a self-clearing init sequence.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             clr_en;
    logic [AW-1:0]    clr_addr;
    logic             run;

    logic [AW-1:0]    wa    [NUM_WR];
    logic [WIDTH-1:0] wd    [NUM_WR];
    logic [NUM_WR-1:0] wr_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == AW'(ZERO_ADDR)));
    endfunction

    regfile_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .run      (run),
        .ready    (ready)
    );

    always_comb begin
        for (int unsigned k = 0; k < NUM_WR; k++) begin
            wa[k]    = wr_addr[k*AW +: AW];
            wd[k]    = wr_data[k*WIDTH +: WIDTH];
            wr_ok[k] = wr_en[k] && run && !rst && addr_ok(wa[k]);
        end
    end

    // Ascending port order: the last non-blocking assignment wins, so the
    // highest-index enabled port takes priority on an address collision.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (wr_ok[k]) mem[wa[k]] <= wd[k];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            logic [AW-1:0]    ra;
            logic [WIDTH-1:0] val;
            ra  = rd_addr[r*AW +: AW];
            val = '0;
            if (run && addr_ok(ra)) begin
                val = mem[ra];
                if (BYPASS != 0) begin
                    for (int unsigned k = 0; k < NUM_WR; k++) begin
                        if (wr_ok[k] && (wa[k] == ra)) val = wd[k];
                    end
                end
            end
            rd_data[r*WIDTH +: WIDTH] = val;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: three parameterisations share clk/rst.
module tb_regfile_mp;

    logic clk;
    logic rst;

    // dut_a: two write ports, bypass on
    logic        ready_a;
    logic [1:0]  wr_en_a;
    logic [9:0]  wr_addr_a;
    logic [63:0] wr_data_a;
    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;

    // dut_b: bypass off
    logic        ready_b;
    logic [0:0]  wr_en_b;
    logic [4:0]  wr_addr_b;
    logic [31:0] wr_data_b;
    logic [9:0]  rd_addr_b;
    logic [63:0] rd_data_b;

    // dut_c: DEPTH = 24
    logic        ready_c;
    logic [0:0]  wr_en_c;
    logic [4:0]  wr_addr_c;
    logic [31:0] wr_data_c;
    logic [9:0]  rd_addr_c;
    logic [63:0] rd_data_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    typedef struct {
        logic [31:0] e0;
        logic [31:0] e1;
    } exp_t;

    exp_t sbq[$];

    regfile_mp #(.NUM_WR(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .ready(ready_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a)
    );

    regfile_mp #(.NUM_WR(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b)
    );

    regfile_mp #(.DEPTH(24)) dut_c (
        .clk(clk), .rst(rst), .ready(ready_c),
        .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
        .rd_addr(rd_addr_c), .rd_data(rd_data_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Counts rising edges after rst falls until each instance raises ready.
    task automatic measure(input string tag);
        int  ea, eb, ec;
        bit  zbad;
        ea = 0; eb = 0; ec = 0; zbad = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            rd_addr_a = {5'(e % 32), 5'((e + 7) % 32)};
            @(posedge clk);
            #1;
            if (!ready_a && rd_data_a !== '0) zbad = 1'b1;
            if (ready_a && ea == 0) ea = e;
            if (ready_b && eb == 0) eb = e;
            if (ready_c && ec == 0) ec = e;
            if (ea != 0 && eb != 0 && ec != 0) break;
        end
        chk({tag, "_ready_a_edge"}, 64'(ea), 64'd32);
        chk({tag, "_ready_b_edge"}, 64'(eb), 64'd32);
        chk({tag, "_ready_c_edge"}, 64'(ec), 64'd24);
        chk({tag, "_zero_while_clear"}, 64'(zbad), 64'd0);
    endtask

    initial begin
        vec_t vecs[11];
        exp_t ex;

        rst = 1'b1;
        wr_en_a = '0; wr_addr_a = '0; wr_data_a = '0; rd_addr_a = '0;
        wr_en_b = '0; wr_addr_b = '0; wr_data_b = '0; rd_addr_b = '0;
        wr_en_c = '0; wr_addr_c = '0; wr_data_c = '0; rd_addr_c = '0;

        //          we     wa0    wd0            wa1    wd1           ra0    ra1    e0             e1
        vecs[0]  = '{2'b01, 5'd20, 32'd50,       5'd0,  32'd0,        5'd20, 5'd20, 32'd50,        32'd50};
        vecs[1]  = '{2'b00, 5'd0,  32'd0,        5'd0,  32'd0,        5'd20, 5'd20, 32'd50,        32'd50};
        vecs[2]  = '{2'b01, 5'd0,  32'hDEADBEEF, 5'd0,  32'd0,        5'd0,  5'd0,  32'd0,         32'd0};
        vecs[3]  = '{2'b00, 5'd0,  32'd0,        5'd0,  32'd0,        5'd0,  5'd20, 32'd0,         32'd50};
        vecs[4]  = '{2'b11, 5'd5,  32'd7,        5'd5,  32'd9,        5'd5,  5'd5,  32'd9,         32'd9};
        vecs[5]  = '{2'b00, 5'd0,  32'd0,        5'd0,  32'd0,        5'd5,  5'd5,  32'd9,         32'd9};
        vecs[6]  = '{2'b11, 5'd6,  32'd7,        5'd7,  32'd9,        5'd6,  5'd7,  32'd7,         32'd9};
        vecs[7]  = '{2'b00, 5'd0,  32'd0,        5'd0,  32'd0,        5'd6,  5'd7,  32'd7,         32'd9};
        vecs[8]  = '{2'b01, 5'd31, 32'h1234,     5'd31, 32'hFFFF,     5'd31, 5'd31, 32'h1234,      32'h1234};
        vecs[9]  = '{2'b11, 5'd21, 32'hBB,       5'd20, 32'hAA,       5'd20, 5'd21, 32'hAA,        32'hBB};
        vecs[10] = '{2'b00, 5'd0,  32'd0,        5'd0,  32'd0,        5'd20, 5'd21, 32'hAA,        32'hBB};

        // Reset and initial clear
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", 64'(ready_a), 64'd0);
        chk("rst_ready_c", 64'(ready_c), 64'd0);
        chk("rst_rd_a", rd_data_a, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        measure("clear");

        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd_addr_a = {5'(a), 5'(31 - a)};
            #1;
            chk($sformatf("sweep_%0d", a), rd_data_a, 64'd0);
        end

        // Table-driven vectors on dut_a
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            wr_en_a   = vecs[i].we;
            wr_addr_a = {vecs[i].wa1, vecs[i].wa0};
            wr_data_a = {vecs[i].wd1, vecs[i].wd0};
            rd_addr_a = {vecs[i].ra1, vecs[i].ra0};
            sbq.push_back('{vecs[i].e0, vecs[i].e1});
            #2;
            ex = sbq.pop_front();
            chk($sformatf("vec%0d_p0", i), 64'(rd_data_a[31:0]), 64'(ex.e0));
            chk($sformatf("vec%0d_p1", i), 64'(rd_data_a[63:32]), 64'(ex.e1));
        end
        @(negedge clk);
        wr_en_a = '0;

        // No bypass: old value in the write cycle, new value one cycle later
        wr_en_b = 1'b1; wr_addr_b = 5'd20; wr_data_b = 32'd50; rd_addr_b = {5'd20, 5'd20};
        #2;
        chk("nobyp_same_cycle", 64'(rd_data_b[63:32]), 64'd0);
        @(negedge clk);
        wr_en_b = 1'b0;
        #2;
        chk("nobyp_next_cycle", 64'(rd_data_b[63:32]), 64'd50);

        // DEPTH = 24: out-of-range write dropped, last entry usable
        @(negedge clk);
        wr_en_c = 1'b1; wr_addr_c = 5'd26; wr_data_c = 32'd11; rd_addr_c = {5'd23, 5'd26};
        #2;
        chk("d24_oob_same", 64'(rd_data_c[31:0]), 64'd0);
        @(negedge clk);
        wr_addr_c = 5'd23;
        #2;
        chk("d24_last_bypass", 64'(rd_data_c[63:32]), 64'd11);
        @(negedge clk);
        wr_en_c = 1'b0;
        #2;
        chk("d24_oob_next", 64'(rd_data_c[31:0]), 64'd0);
        chk("d24_last_stored", 64'(rd_data_c[63:32]), 64'd11);

        // Reset mid-clear wipes earlier contents and restarts the count
        @(negedge clk);
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd3}; wr_data_a = {32'd0, 32'd33};
        @(negedge clk);
        wr_en_a = '0; rd_addr_a = {5'd3, 5'd3};
        #2;
        chk("r3_before_reset", 64'(rd_data_a[31:0]), 64'd33);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd3}; wr_data_a = {32'd0, 32'd77};
        @(negedge clk);
        rst = 1'b0;
        wr_en_a = '0;
        measure("midclr");
        @(negedge clk);
        rd_addr_a = {5'd3, 5'd3};
        #2;
        chk("r3_after_reset", 64'(rd_data_a[31:0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
